md5_padder: RTL and testbench
=============================

# md5_padder

MD5 message-block formatter: the producer side of the 512-bit `message` bus consumed by the MD5 hash core. It accepts an arbitrary-length byte message as a stream of 32-bit words and performs RFC 1321 padding: the 0x80 marker, zero fill, and the 64-bit little-endian bit length. It emits complete 512-bit blocks over a valid/ready handshake, with first/last flags so the downstream chaining logic knows when to load the IV and when the digest is final.

## Interface
- `LEN_W`, default 32: width of the internal byte counter. Bit length = `{count,3'b000}` zero-extended to 64 bits; the counter wraps mod 2^LEN_W.
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: padder accepts a word this cycle.
- `in_data` input 32: message bytes; byte 0 of the word in [7:0], byte 3 in [31:24].
- `in_last` input 1: this beat ends the message.
- `in_bytes` input 3: valid bytes in a last beat, 0–4; values 5–7 are treated as 4; ignored when `in_last`=0 (4 bytes).
- `out_valid` output 1: `out_block` valid.
- `out_ready` input 1: downstream accepts the block.
- `out_block` output 512: block; byte n at [8n+7:8n]; word i at [32i+31:32i].
- `out_first` output 1: block is the first of its message.
- `out_last` output 1: block is the final (length-bearing) block of its message.

## Operation
- Transfers occur only when valid and ready are both high on a clock edge. Input and output are handled independently.
- Internal state:
  - 16-word assembly buffer;
  - word index `widx` (0–15);
  - byte counter `count`;
  - `first_pending` flag, set at reset and after each final block;
  - extra-block type: NONE, ZERO, or MARK.
- FSM has three states: FILL, EMIT, EXTRA.
- FILL:
  - `in_ready`=1.
  - A non-last beat is written to word `widx`, `widx`++ and `count`+=4.
  - When the beat at `widx`=15 is accepted, go to EMIT with `out_last`=0.
- Last beat, with `p = 4*widx + in_bytes`:
  - Store the valid bytes, zero the invalid bytes of the word, and set `count`+=`in_bytes`.
  - p ≤ 55: write 0x80 at byte p, zero bytes p+1..55, put the length in bytes 56–63; go to EMIT with `out_last`=1.
  - 56 ≤ p ≤ 63: write 0x80 at byte p, zero the remaining bytes; go to EMIT with `out_last`=0 and extra=ZERO.
  - p = 64: emit the data block with `out_last`=0 and extra=MARK.
- EMIT:
  - `out_valid`=1 and `in_ready`=0.
  - `out_first` = `first_pending`.
  - On handshake: clear `first_pending`. If extra≠NONE go to EXTRA. Otherwise go to FILL with `widx`=0; if `out_last`=1, also clear `count` and set `first_pending`.
- EXTRA:
  - Load the buffer with zeros plus the length in bytes 56–63; MARK also sets byte 0 = 0x80.
  - Go to EMIT with `out_last`=1 and extra=NONE.
- Empty message (`in_last`, `in_bytes`=0, `widx`=0): one block with byte0=0x80 and length 0.
- Reset mid-operation discards any partial message and returns to FILL with `widx`=0, `count`=0, `first_pending`=1.

## Timing
- Reset values:
  - `in_ready`=1 (FILL);
  - `out_valid`=0;
  - `out_block`=0;
  - `out_first`=0;
  - `out_last`=0.
- `out_valid` rises the cycle after the handshake of the 16th word or the last beat. An EXTRA block adds one cycle after the preceding output handshake.
- While `out_valid`=1 and `out_ready`=0, `out_block`, `out_first` and `out_last` hold stable. `out_valid` never drops without a handshake.
- Peak throughput without the option: 17 cycles per block (16 accepts + 1 emit).
- All outputs are registered or decoded only from state; there are no combinational paths from inputs to outputs.

## Configuration
- `MD5_PADDER_OVERLAP_EN` defined:
  - A second 512-bit output holding register is added.
  - A completed block is copied into it when it is empty or draining that cycle, and FILL resumes immediately. `in_ready` drops only while a completed block waits for the holding register or an extra block is pending.
  - Peak throughput becomes 16 cycles per block.
  - Latency is unchanged.
- Undefined: single buffer; `in_ready`=0 throughout EMIT and EXTRA.

## Test plan
- Empty message (`in_last`=1, `in_bytes`=0) -> one block: `out_block[7:0]`=8'h80, all other bits 0, `out_first`=`out_last`=1.
- "abc" (`in_data`=32'h00636261, `in_bytes`=3, last) -> `out_block[31:0]`=32'h80636261, `[511:448]`=64'd24, rest 0. Driving the MD5 core with this block gives digest 900150983cd24fb0d6963f7d28e17f72.
- 56-byte message (14 full words, last `in_bytes`=4) -> two blocks:
  - first block: byte56=0x80, `out_first`=1, `out_last`=0;
  - second block: zeros except `[511:448]`=64'd448, `out_first`=0, `out_last`=1.
- 64-byte message -> data block with `out_last`=0, then a block with byte0=0x80 and length 64'd512, `out_last`=1.
- Hold `out_ready`=0 for 10 cycles during EMIT with `in_valid`=1 -> `out_block` stable, no input accepted (without the macro), correct block delivered on release.
- Assert `reset_n`=0 after 7 words -> all outputs at reset values. A following "abc" message yields the single correct block with `out_first`=1.

Source files
------------

// File: rtl/md5_padder.sv
// md5_padder: RFC 1321 padder turning a 32-bit byte stream into 512-bit MD5 message blocks.
// Optional `MD5_PADDER_OVERLAP_EN adds an output holding register so filling overlaps draining.
module md5_padder #(
  parameter int LEN_W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_first,
  output logic         out_last
);

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_e;
  typedef enum logic [1:0] {NONE, ZERO, MARK} extra_e;

  state_e           state;
  extra_e           extra;
  logic [511:0]     blk_q;
  logic [3:0]       widx;
  logic [LEN_W-1:0] count;
  logic             first_pending;

  logic [2:0]       beat_bytes;
  logic [6:0]       base;
  logic [6:0]       p;
  logic [LEN_W-1:0] count_next;
  logic [63:0]      len_next;
  logic [63:0]      len_cur;
  logic [511:0]     fill_block;
  logic [511:0]     extra_block;
  logic             in_fire;
  logic             block_done;
  logic             done_last;
  extra_e           done_extra;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    beat_bytes = 3'd4;
    if (in_last && in_bytes < 3'd4) beat_bytes = in_bytes;
  end

  assign base       = {1'b0, widx, 2'b00};
  assign p          = base + {4'd0, beat_bytes};
  assign count_next = count + LEN_W'(beat_bytes);
  assign len_next   = 64'({count_next, 3'b000});
  assign len_cur    = 64'({count, 3'b000});
  assign in_fire    = in_valid & in_ready;
  assign block_done = in_fire & (in_last | (widx == 4'd15));

  // Block image after this beat: data bytes land in word widx; a last beat also
  // lays down the marker, zero fill and (when it fits) the length.
  always_comb begin
    fill_block = blk_q;
    for (int n = 0; n < 64; n++) begin
      if (7'(n) >= base && 7'(n) < p)
        fill_block[8*n +: 8] = in_data[8*(n % 4) +: 8];
      else if (in_last && 7'(n) == p)
        fill_block[8*n +: 8] = 8'h80;
      else if (in_last && 7'(n) > p)
        fill_block[8*n +: 8] = (n >= 56 && p <= 7'd55) ? len_next[8*(n % 8) +: 8] : 8'h00;
    end
  end

  always_comb begin
    done_last  = 1'b0;
    done_extra = NONE;
    if (in_last) begin
      if (p <= 7'd55)      done_last  = 1'b1;
      else if (p == 7'd64) done_extra = MARK;
      else                 done_extra = ZERO;
    end
  end

  always_comb begin
    extra_block = {len_cur, 448'd0};
    if (extra == MARK) extra_block[7:0] = 8'h80;
  end

`ifdef MD5_PADDER_OVERLAP_EN
  logic pend_last;
  logic hold_free;

  assign hold_free = !out_valid || out_ready;
  assign in_ready  = (state == FILL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FILL;
      extra         <= NONE;
      blk_q         <= '0;
      widx          <= '0;
      count         <= '0;
      first_pending <= 1'b1;
      pend_last     <= 1'b0;
      out_valid     <= 1'b0;
      out_block     <= '0;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      // A load below in the same cycle overrides this drain.
      if (out_ready) out_valid <= 1'b0;
      case (state)
        FILL: if (in_fire) begin
          blk_q <= fill_block;
          count <= count_next;
          widx  <= block_done ? 4'd0 : widx + 4'd1;
          if (block_done) begin
            extra     <= done_extra;
            pend_last <= done_last;
            if (hold_free) begin
              out_block     <= fill_block;
              out_valid     <= 1'b1;
              out_first     <= first_pending;
              out_last      <= done_last;
              first_pending <= done_last;
              if (done_last) count <= '0;
              if (done_extra != NONE) state <= EXTRA;
            end else begin
              state <= EMIT;
            end
          end
        end
        EMIT: if (hold_free) begin
          out_block     <= blk_q;
          out_valid     <= 1'b1;
          out_first     <= first_pending;
          out_last      <= pend_last;
          first_pending <= pend_last;
          if (pend_last) count <= '0;
          state <= (extra != NONE) ? EXTRA : FILL;
        end
        EXTRA: if (hold_free) begin
          out_block     <= extra_block;
          out_valid     <= 1'b1;
          out_first     <= first_pending;
          out_last      <= 1'b1;
          first_pending <= 1'b1;
          count         <= '0;
          extra         <= NONE;
          state         <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
`else
  assign in_ready  = (state == FILL);
  assign out_valid = (state == EMIT);
  assign out_block = blk_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FILL;
      extra         <= NONE;
      // NOTE: the assembly buffer is reset because it drives out_block directly and must read zero after reset.
      blk_q         <= '0;
      widx          <= '0;
      count         <= '0;
      first_pending <= 1'b1;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      case (state)
        FILL: if (in_fire) begin
          blk_q <= fill_block;
          count <= count_next;
          widx  <= block_done ? 4'd0 : widx + 4'd1;
          if (block_done) begin
            state     <= EMIT;
            out_first <= first_pending;
            out_last  <= done_last;
            extra     <= done_extra;
          end
        end
        EMIT: if (out_ready) begin
          first_pending <= 1'b0;
          if (extra != NONE) begin
            state <= EXTRA;
          end else begin
            state <= FILL;
            widx  <= '0;
            if (out_last) begin
              count         <= '0;
              first_pending <= 1'b1;
            end
          end
        end
        EXTRA: begin
          blk_q     <= extra_block;
          out_first <= first_pending;
          out_last  <= 1'b1;
          extra     <= NONE;
          state     <= EMIT;
        end
        default: state <= FILL;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_md5_padder.sv
// tb_md5_padder: random messages against a byte-level RFC 1321 padding model, plus directed
// empty / "abc" / 56 / 64-byte, output stall and mid-message reset steps.
module tb_md5_padder;

  typedef logic [7:0] byte_q_t [$];

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;

  md5_padder #(.LEN_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int stab_err = 0;
  bit rand_ready = 1'b0;
  bit timed_out = 1'b0;

  logic [511:0] obs_blk [$];
  logic [511:0] exp_blk [$];
  logic [1:0]   obs_fl  [$];
  logic [1:0]   exp_fl  [$];

  logic         prev_stall = 1'b0;
  logic [511:0] prev_blk = '0;
  logic [1:0]   prev_fl = '0;

  // Record accepted blocks and watch that a stalled block holds still.
  always @(negedge clock) begin
    if (reset_n && prev_stall &&
        !(out_valid && out_block === prev_blk && {out_first, out_last} === prev_fl))
      stab_err++;
    prev_stall = reset_n && out_valid && !out_ready;
    prev_blk   = out_block;
    prev_fl    = {out_first, out_last};
    if (reset_n && out_valid && out_ready) begin
      obs_blk.push_back(out_block);
      obs_fl.push_back({out_first, out_last});
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic byte_q_t rand_msg(input int len);
    byte_q_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  function automatic logic [31:0] word_of(input byte_q_t m, input int b);
    logic [31:0] w;
    w = $urandom;
    for (int k = 0; k < 4; k++)
      if (4*b + k < m.size()) w[8*k +: 8] = m[4*b + k];
    return w;
  endfunction

  function automatic logic [511:0] obs_at(input int i);
    return (i < obs_blk.size()) ? obs_blk[i] : 'x;
  endfunction

  function automatic logic [1:0] obs_fl_at(input int i);
    return (i < obs_fl.size()) ? obs_fl[i] : 'x;
  endfunction

  // Reference: append 0x80, zero to 56 mod 64, then the 64-bit little-endian bit length.
  task automatic build_expected(input byte_q_t msg);
    byte_q_t pad;
    logic [63:0] bits;
    logic [511:0] blk;
    int nblk;
    pad = msg;
    bits = 64'(msg.size()) * 64'd8;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int i = 0; i < 8; i++) pad.push_back(bits[8*i +: 8]);
    nblk = pad.size() / 64;
    exp_blk.delete();
    exp_fl.delete();
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) blk[8*i +: 8] = pad[64*b + i];
      exp_blk.push_back(blk);
      exp_fl.push_back({b == 0, b == nblk - 1});
    end
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last, input logic [2:0] nbytes);
    int guard;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    in_bytes = nbytes;
    guard = 0;
    while (!in_ready && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400) timed_out = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t msg);
    int nbeats;
    int nb;
    logic last;
    logic [2:0] nbytes;
    nbeats = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      nb = msg.size() - 4*b;
      if (nb > 4) nb = 4;
      last = (b == nbeats - 1);
      nbytes = last ? 3'(nb) : 3'($urandom_range(0, 7));
      if (last && nb == 4 && $urandom_range(0, 1) == 1) nbytes = 3'($urandom_range(5, 7));
      if ($urandom_range(0, 3) == 0) tick();
      send_beat(word_of(msg, b), last, nbytes);
    end
    check($sformatf("len%0d_valid_rise", msg.size()), 512'(out_valid), 512'(1));
  endtask

  task automatic collect_and_compare(input int len);
    int guard;
    guard = 0;
    while (obs_blk.size() < exp_blk.size() && guard < 300) begin
      tick();
      guard++;
    end
    repeat (4) tick();
    check($sformatf("len%0d_block_count", len), 512'(obs_blk.size()), 512'(exp_blk.size()));
    for (int i = 0; i < exp_blk.size(); i++) begin
      check($sformatf("len%0d_blk%0d", len, i), obs_at(i), exp_blk[i]);
      check($sformatf("len%0d_flags%0d", len, i), 512'(obs_fl_at(i)), 512'(exp_fl[i]));
    end
    check($sformatf("len%0d_hold_stable", len), 512'(stab_err), 512'(0));
    check($sformatf("len%0d_in_wait", len), 512'(timed_out), 512'(0));
  endtask

  task automatic run_msg(input byte_q_t msg);
    obs_blk.delete();
    obs_fl.delete();
    timed_out = 1'b0;
    build_expected(msg);
    send_msg(msg);
    collect_and_compare(msg.size());
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  512'(in_ready),  512'(1));
    check({tag, "_out_valid"}, 512'(out_valid), 512'(0));
    check({tag, "_out_block"}, out_block,       512'(0));
    check({tag, "_out_first"}, 512'(out_first), 512'(0));
    check({tag, "_out_last"},  512'(out_last),  512'(0));
  endtask

  initial begin
    byte_q_t m;
    logic [511:0] snap;
    logic [511:0] b0;
    logic [511:0] b1;
    bit same;
    int acc;
    int lens [10] = '{0, 3, 55, 56, 63, 64, 119, 120, 127, 128};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    check_reset("por");
    reset_n = 1'b1;
    tick();
    rand_ready = 1'b1;

    m.delete();
    run_msg(m);
    check("empty_blk", obs_at(0), 512'h80);

    m = {8'h61, 8'h62, 8'h63};
    run_msg(m);
    check("abc_blk", obs_at(0), {64'd24, 416'd0, 32'h80636261});

    m = rand_msg(56);
    run_msg(m);
    b0 = obs_at(0);
    b1 = obs_at(1);
    check("m56_marker", 512'(b0[455:448]), 512'(8'h80));
    check("m56_len_blk", b1, {64'd448, 448'd0});

    m = rand_msg(64);
    run_msg(m);
    b1 = obs_at(1);
    check("m64_mark_blk", b1, {64'd512, 440'd0, 8'h80});

    // Output stall: 16 words fill a block, downstream refuses it for 10 cycles.
    m = rand_msg(80);
    obs_blk.delete();
    obs_fl.delete();
    timed_out = 1'b0;
    build_expected(m);
    rand_ready = 1'b0;
    out_ready  = 1'b0;
    for (int b = 0; b < 16; b++) send_beat(word_of(m, b), 1'b0, 3'd0);
    snap = out_block;
    same = 1'b1;
    acc  = 0;
`ifndef MD5_PADDER_OVERLAP_EN
    in_valid = 1'b1;
    in_data  = word_of(m, 16);
`endif
    repeat (10) begin
      if (in_valid && in_ready) acc++;
      tick();
      if (!out_valid || out_block !== snap) same = 1'b0;
    end
    in_valid = 1'b0;
    check("stall_block_stable", 512'(same), 512'(1));
    check("stall_no_accept", 512'(acc), 512'(0));
    check("stall_block_value", snap, exp_blk[0]);
    out_ready  = 1'b1;
    rand_ready = 1'b1;
    for (int b = 16; b < 20; b++) send_beat(word_of(m, b), b == 19, 3'd4);
    collect_and_compare(80);

    // Reset in the middle of a message.
    m = rand_msg(40);
    for (int b = 0; b < 7; b++) send_beat(word_of(m, b), 1'b0, 3'd0);
    reset_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m);
    check("post_rst_abc_blk", obs_at(0), {64'd24, 416'd0, 32'h80636261});
    check("post_rst_abc_flags", 512'(obs_fl_at(0)), 512'(2'b11));

    foreach (lens[i]) begin
      m = rand_msg(lens[i]);
      run_msg(m);
    end
    repeat (20) begin
      m = rand_msg($urandom_range(0, 200));
      run_msg(m);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
